// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port.
// NREQ requesters compete through a valid/ready handshake. The winning write
// is flopped onto we3/a3/wd3, so the register file sees clean registered
// signals one cycle after the grant. A per-register pending scoreboard tracks
// outstanding producers for issue-stage hazard checks.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_hold,
  input  logic                 mark_valid,
  input  logic [AW-1:0]        mark_addr,
  output logic                 we3,
  output logic [AW-1:0]        a3,
  output logic [DW-1:0]        wd3,
  output logic [(1<<AW)-1:0]   pending
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_next;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   scan_idx;
  logic            transfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NREG-1:0] pending_next;

  // Round-robin scan starting at ptr; the grant depends only on valid, ptr and hold.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    req_ready = '0;
    grant_idx = '0;
    scan_idx  = '0;
    transfer  = 1'b0;
    if (!wb_hold) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = IW'((int'(ptr) + k) % NREQ);
        if (!transfer && req_valid[scan_idx]) begin
          transfer            = 1'b1;
          grant_idx           = scan_idx;
          req_ready[scan_idx] = 1'b1;
        end
      end
    end
  end

  // Winner's payload and the pointer that follows it.
  always_comb begin
    sel_addr = req_addr[grant_idx*AW +: AW];
    sel_data = req_data[grant_idx*DW +: DW];
    ptr_next = ptr;
    if (transfer) begin
      ptr_next = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Scoreboard: commit clears, a new mark sets, and the set wins a collision.
  always_comb begin
    pending_next = pending;
    if (we3) begin
      pending_next[a3] = 1'b0;
    end
    if (mark_valid && (mark_addr != '0)) begin
      pending_next[mark_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Pointer, registered write port and scoreboard state.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the scoreboard is a bank of flops rather than a RAM, so it is
    // cleared by reset like any other state; a RAM could not be.
    if (!reset) begin
      ptr     <= '0;
      we3     <= 1'b0;
      a3      <= '0;
      wd3     <= '0;
      pending <= '0;
    end else begin
      // NOTE: non-blocking assignments here keep every flop sampling
      // pre-edge values, independent of statement order.
      ptr     <= ptr_next;
      pending <= pending_next;
      if (transfer) begin
        a3  <= sel_addr;
        wd3 <= sel_data;
        we3 <= (sel_addr != '0);
      end else begin
        we3 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32).
// Inputs are driven 1ns after a rising edge. Combinational outputs are
// sampled 1ns after that, and registered outputs 1ns after the next edge.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                clock;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                wb_hold;
  logic                mark_valid;
  logic [AW-1:0]       mark_addr;
  logic                we3;
  logic [AW-1:0]       a3;
  logic [DW-1:0]       wd3;
  logic [(1<<AW)-1:0]  pending;

  int passed;
  int total;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wb_hold    (wb_hold),
    .mark_valid (mark_valid),
    .mark_addr  (mark_addr),
    .we3        (we3),
    .a3         (a3),
    .wd3        (wd3),
    .pending    (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_addr[i*AW +: AW] = addr;
    req_data[i*DW +: DW] = data;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    reset      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    wb_hold    = 1'b0;
    mark_valid = 1'b0;
    mark_addr  = '0;

    // Reset state.
    #12;
    check("rst_we3", 64'(we3), 64'd0);
    check("rst_a3", 64'(a3), 64'd0);
    check("rst_wd3", 64'(wd3), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    reset = 1'b1;
    step();

    // Latency/data: only requester 1 is valid. The pointer moves to 2.
    set_req(1, 5'd9, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    check("lat_ready", 64'(req_ready), 64'b010);
    step();
    check("lat_we3", 64'(we3), 64'd1);
    check("lat_a3", 64'(a3), 64'd9);
    check("lat_wd3", 64'(wd3), 64'hDEADBEEF);
    req_valid = '0;
    step();
    check("lat_we3_drop", 64'(we3), 64'd0);
    check("lat_a3_hold", 64'(a3), 64'd9);
    check("lat_wd3_hold", 64'(wd3), 64'hDEADBEEF);

    // R0 discard: requester 2 writes addr 0. The pointer moves to 0.
    set_req(2, 5'd0, 32'h1234);
    req_valid = 3'b100;
    #1;
    check("r0_ready", 64'(req_ready), 64'b100);
    step();
    check("r0_we3", 64'(we3), 64'd0);
    check("r0_wd3", 64'(wd3), 64'h1234);
    check("r0_pending", 64'(pending), 64'd0);
    req_valid = '0;

    // Scoreboard set, then clear on the commit edge.
    mark_valid = 1'b1;
    mark_addr  = 5'd5;
    step();
    check("sb_set", 64'(pending), 64'h20);
    mark_valid = 1'b0;
    set_req(0, 5'd5, 32'hA5);
    req_valid = 3'b001;
    #1;
    check("sb_wr_ready", 64'(req_ready), 64'b001);
    step();
    check("sb_wr_we3", 64'(we3), 64'd1);
    check("sb_wr_a3", 64'(a3), 64'd5);
    check("sb_still_set", 64'(pending), 64'h20);
    req_valid = '0;
    step();
    check("sb_cleared", 64'(pending), 64'd0);

    // Mark on the same edge as a commit to the same register: set wins.
    set_req(1, 5'd5, 32'h55);
    req_valid = 3'b010;
    #1;
    check("sb2_ready", 64'(req_ready), 64'b010);
    step();
    check("sb2_we3", 64'(we3), 64'd1);
    req_valid  = '0;
    mark_valid = 1'b1;
    mark_addr  = 5'd5;
    step();
    check("sb_set_wins", 64'(pending), 64'h20);
    mark_addr = 5'd0;
    step();
    check("sb_mark_r0", 64'(pending), 64'h20);
    mark_valid = 1'b0;

    // Reset mid-write: requester 2 (pointer is 2) puts addr 7 in flight.
    set_req(2, 5'd7, 32'h77);
    req_valid = 3'b100;
    #1;
    check("mid_ready", 64'(req_ready), 64'b100);
    step();
    check("mid_we3", 64'(we3), 64'd1);
    check("mid_a3", 64'(a3), 64'd7);
    req_valid = '0;
    reset     = 1'b0;
    #1;
    check("mid_rst_we3", 64'(we3), 64'd0);
    check("mid_rst_a3", 64'(a3), 64'd0);
    check("mid_rst_pending", 64'(pending), 64'd0);
    step();
    reset = 1'b1;

    // Round robin with all requesters valid, starting from requester 0.
    set_req(0, 5'd10, 32'h100);
    set_req(1, 5'd11, 32'h101);
    set_req(2, 5'd12, 32'h102);
    req_valid = 3'b111;
    for (int c = 0; c < 7; c++) begin
      #1;
      check($sformatf("rr_ready_%0d", c), 64'(req_ready), 64'(1 << (c % 3)));
      step();
      check($sformatf("rr_we3_%0d", c), 64'(we3), 64'd1);
      check($sformatf("rr_a3_%0d", c), 64'(a3), 64'(10 + (c % 3)));
      check($sformatf("rr_wd3_%0d", c), 64'(wd3), 64'(32'h100 + (c % 3)));
    end

    // Hold with the pointer at 1: the in-flight write from requester 0 drains.
    wb_hold = 1'b1;
    #1;
    check("hold_inflight_we3", 64'(we3), 64'd1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("hold_ready_%0d", c), 64'(req_ready), 64'd0);
      step();
      check($sformatf("hold_we3_%0d", c), 64'(we3), 64'd0);
    end
    wb_hold = 1'b0;
    #1;
    check("release_ready", 64'(req_ready), 64'b010);
    step();
    check("release_we3", 64'(we3), 64'd1);
    check("release_a3", 64'(a3), 64'd11);
    req_valid = '0;
    step();
    check("final_we3", 64'(we3), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/a3/wd3) between NREQ writeback requesters, such as the ALU, load unit and multiplier.
- Uses a round-robin valid/ready handshake.
- Registers the winning write so the port sees clean, flopped signals.
- Keeps a per-register pending scoreboard for issue-stage hazard checks. Sits between execution units and register_file.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width (2^AW registers).
- DW, 32, data width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  destination of requester i, at bits [i*AW +: AW]
- req_data  in  NREQ*DW  data of requester i, at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; the write is accepted this cycle
- wb_hold  in  1  freeze arbitration, e.g. during a pipeline stall
- mark_valid  in  1  issue stage marks a destination register as pending
- mark_addr  in  AW  register to mark
- we3  out  1  register-file write enable
- a3  out  AW  register-file write address
- wd3  out  DW  register-file write data
- pending  out  2^AW  scoreboard; bit r=1 means a write to r is outstanding

Behaviour:
- Reset (reset=0, asynchronous):
  - we3=0, a3=0, wd3=0, pending=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - All state holds until reset returns to 1. There are no partial writes: an in-flight registered write is dropped and we3 goes low immediately.
- Arbitration (combinational):
  - Candidates are the set of req_valid[i] when wb_hold=0.
  - The grant goes to the first candidate found scanning i = ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - req_ready is one-hot or zero. It depends only on req_valid, ptr and wb_hold, never on req_addr or req_data.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i]=1 and req_ready[i]=1.
  - A requester holds valid, addr and data stable until accepted.
  - The arbiter does not require valid to stay high once dropped.
- Pointer update: on a transfer from requester g, ptr <= (g+1) mod NREQ. With no transfer, ptr holds.
- Write path (1-cycle latency): on a transfer,
  - a3 <= req_addr[g] and wd3 <= req_data[g].
  - we3 <= 1 if req_addr[g] != 0; if req_addr[g] == 0, we3 <= 0 (writes to R0 are consumed and discarded).
  - With no transfer, we3 <= 0 while a3 and wd3 hold their last values.
  - Throughput: one write per cycle.
- wb_hold=1:
  - req_ready=0 and ptr holds.
  - A write already registered still completes: we3 stays as registered for that one cycle, then goes 0.
- Scoreboard, evaluated per rising edge:
  - Set: mark_valid=1 and mark_addr != 0 sets pending[mark_addr].
  - Clear: we3=1 in the current cycle clears pending[a3] (the commit edge).
  - Same register set and cleared on the same edge: set wins, because a new producer is outstanding.
  - pending[0] is always 0.
  - A transfer with pending[addr]=0 is legal; it writes and leaves pending unchanged.
  - pending is a registered output.
- Simultaneous events:
  - All NREQ requesters valid: exactly one is granted per cycle, and each is served within NREQ cycles (starvation-free).
  - Two requesters targeting the same register in consecutive cycles both write in grant order; the later write wins in the register file.

Test Plan:
- Reset: drive reset=0 mid-write with we3=1, a3=7 -> we3=0, a3=0, pending=0 immediately; after reset=1, the first grant with all valid goes to requester 0.
- Round robin: NREQ=3, all valid continuously -> req_ready sequence 001, 010, 100, 001…; we3=1 every cycle starting one cycle after the first grant; a3 and wd3 follow the grant order.
- Latency/data: only requester 1 valid with addr=9, data=0xDEADBEEF -> req_ready=010 that cycle; next cycle we3=1, a3=9, wd3=0xDEADBEEF; the cycle after, we3=0.
- R0 discard: requester 2 writes addr=0 with data=0x1234 -> accepted (req_ready=100), we3 stays 0, pending unchanged.
- Scoreboard:
  - mark_addr=5 -> pending[5]=1 next edge; a later requester write to 5 commits -> pending[5]=0 on the commit edge.
  - mark 5 on the same edge as a commit to 5 -> pending[5] remains 1.
  - mark_addr=0 -> no bit set.
- Hold: all valid, ptr=1, wb_hold=1 for 3 cycles -> req_ready=000 and we3=0 after the in-flight write drains; on release the first grant goes to requester 1.
